// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD write-port arbiter: owner codes, FSM states, word layout.
package lcd_pkg;

  localparam int LCD_DW = 9;
  localparam int DC_BIT = 8;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INIT = 2'd1;
  localparam logic [1:0] OWN_PIC  = 2'd2;
  localparam logic [1:0] OWN_CHR  = 2'd3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_PIC,
    S_CHR,
    S_GAP
  } arb_state_t;

  function automatic logic [1:0] owner_of(arb_state_t s);
    case (s)
      S_INIT:  return OWN_INIT;
      S_PIC:   return OWN_PIC;
      S_CHR:   return OWN_CHR;
      default: return OWN_NONE;
    endcase
  endfunction

  function automatic logic is_data_word(logic [LCD_DW-1:0] w);
    return w[DC_BIT];
  endfunction

endpackage

// File: rtl/lcd_arb_watchdog.sv
// Idle-cycle counter for the granted requester; expire pulses when the
// TIMEOUT-th consecutive idle cycle is seen.
module lcd_arb_watchdog #(
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic sys_clk_50MHz,
  input  logic sys_rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  assign expire = inc & (cnt == LAST);

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst)
      cnt <= '0;
    else if (clr || expire)
      cnt <= '0;
    else if (inc)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Arbitrates the 9-bit LCD write port between init, picture and overlay writers.
// Optional statistics outputs are built when LCD_ARB_STATS_EN is defined.
//
// state  | meaning
// S_INIT | init sequencer owns the port
// S_IDLE | no owner, picking next burst (round-robin)
// S_PIC  | picture writer owns the port
// S_CHR  | overlay writer owns the port
// S_GAP  | one turnaround cycle after a burst ends or is revoked
module lcd_write_arbiter
  import lcd_pkg::*;
#(
  parameter int DATA_W  = LCD_DW,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 11
) (
  input  logic              sys_clk_50MHz,
  input  logic              sys_rst,
  input  logic              init_done,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_valid,
  output logic              init_ready,
  input  logic              pic_req,
  input  logic [DATA_W-1:0] pic_data,
  input  logic              pic_valid,
  output logic              pic_ready,
  output logic              pic_grant,
  input  logic              chr_req,
  input  logic [DATA_W-1:0] chr_data,
  input  logic              chr_valid,
  output logic              chr_ready,
  output logic              chr_grant,
  input  logic              wr_ready,
  output logic [DATA_W-1:0] data,
  output logic              en_write,
  output logic [1:0]        owner,
  output logic              timeout
`ifdef LCD_ARB_STATS_EN
  ,
  output logic [15:0]       stat_pic_words,
  output logic [15:0]       stat_chr_words,
  output logic [7:0]        stat_timeouts
`endif
);

  arb_state_t        state, state_nxt;
  logic              rr_last_chr, rr_nxt;
  logic              to_nxt;
  logic              init_acc, pic_acc, chr_acc, any_acc;
  logic [DATA_W-1:0] acc_word;
  logic              wd_clr, wd_inc, wd_expire;

  // Readiness is gated by registered ownership so reset and grant edges stay clean;
  // a requester dropping req loses ready in the same cycle.
  assign init_ready = (owner == OWN_INIT) & wr_ready;
  assign pic_ready  = pic_grant & pic_req & wr_ready;
  assign chr_ready  = chr_grant & chr_req & wr_ready;

  assign init_acc = init_valid & init_ready;
  assign pic_acc  = pic_valid & pic_ready;
  assign chr_acc  = chr_valid & chr_ready;
  assign any_acc  = init_acc | pic_acc | chr_acc;
  assign acc_word = init_acc ? init_data : (pic_acc ? pic_data : chr_data);

  assign wd_clr = ~(pic_grant | chr_grant) | pic_acc | chr_acc;
  assign wd_inc = wr_ready & ((pic_grant & pic_req & ~pic_valid) |
                              (chr_grant & chr_req & ~chr_valid));

  lcd_arb_watchdog #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_wd (
    .sys_clk_50MHz(sys_clk_50MHz),
    .sys_rst      (sys_rst),
    .clr          (wd_clr),
    .inc          (wd_inc),
    .expire       (wd_expire)
  );

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_last_chr;
    to_nxt    = 1'b0;
    if (!init_done) begin
      state_nxt = S_INIT;
    end else begin
      case (state)
        S_INIT: if (!init_acc) state_nxt = S_IDLE;
        S_IDLE: begin
          if (pic_req && (!chr_req || rr_last_chr)) state_nxt = S_PIC;
          else if (chr_req)                         state_nxt = S_CHR;
        end
        S_PIC: begin
          if (!pic_req) begin
            state_nxt = S_GAP;
            rr_nxt    = 1'b0;
          end else if (wd_expire) begin
            state_nxt = S_GAP;
            rr_nxt    = 1'b0;
            to_nxt    = 1'b1;
          end
        end
        S_CHR: begin
          if (!chr_req) begin
            state_nxt = S_GAP;
            rr_nxt    = 1'b1;
          end else if (wd_expire) begin
            state_nxt = S_GAP;
            rr_nxt    = 1'b1;
            to_nxt    = 1'b1;
          end
        end
        S_GAP:   state_nxt = S_IDLE;
        default: state_nxt = S_INIT;
      endcase
    end
  end

  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= S_INIT;
      rr_last_chr <= 1'b1;
      owner       <= OWN_NONE;
      pic_grant   <= 1'b0;
      chr_grant   <= 1'b0;
      timeout     <= 1'b0;
      en_write    <= 1'b0;
      data        <= '0;
    end else begin
      state       <= state_nxt;
      rr_last_chr <= rr_nxt;
      owner       <= owner_of(state_nxt);
      pic_grant   <= (state_nxt == S_PIC);
      chr_grant   <= (state_nxt == S_CHR);
      timeout     <= to_nxt;
      en_write    <= any_acc;
      if (any_acc) data <= acc_word;
    end
  end

`ifdef LCD_ARB_STATS_EN
  always_ff @(posedge sys_clk_50MHz or posedge sys_rst) begin
    if (sys_rst) begin
      stat_pic_words <= '0;
      stat_chr_words <= '0;
      stat_timeouts  <= '0;
    end else begin
      if (pic_acc && stat_pic_words != '1) stat_pic_words <= stat_pic_words + 1'b1;
      if (chr_acc && stat_chr_words != '1) stat_chr_words <= stat_chr_words + 1'b1;
      if (to_nxt && stat_timeouts != '1)   stat_timeouts  <= stat_timeouts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Directed cycle-trace bench for lcd_write_arbiter (TIMEOUT=16), plus hand
// sequences for watchdog revoke, re-init mid-burst and async reset.
module tb_lcd_write_arbiter;

  logic       sys_clk_50MHz = 1'b0;
  logic       sys_rst;
  logic       init_done, init_valid, init_ready;
  logic [8:0] init_data, pic_data, chr_data, data;
  logic       pic_req, pic_valid, pic_ready, pic_grant;
  logic       chr_req, chr_valid, chr_ready, chr_grant;
  logic       wr_ready, en_write, timeout;
  logic [1:0] owner;
`ifdef LCD_ARB_STATS_EN
  logic [15:0] stat_pic_words, stat_chr_words;
  logic [7:0]  stat_timeouts;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 sys_clk_50MHz = ~sys_clk_50MHz;

  lcd_write_arbiter #(.DATA_W(9), .TIMEOUT(16), .TO_W(5)) dut (
    .sys_clk_50MHz(sys_clk_50MHz),
    .sys_rst      (sys_rst),
    .init_done    (init_done),
    .init_data    (init_data),
    .init_valid   (init_valid),
    .init_ready   (init_ready),
    .pic_req      (pic_req),
    .pic_data     (pic_data),
    .pic_valid    (pic_valid),
    .pic_ready    (pic_ready),
    .pic_grant    (pic_grant),
    .chr_req      (chr_req),
    .chr_data     (chr_data),
    .chr_valid    (chr_valid),
    .chr_ready    (chr_ready),
    .chr_grant    (chr_grant),
    .wr_ready     (wr_ready),
    .data         (data),
    .en_write     (en_write),
    .owner        (owner),
    .timeout      (timeout)
`ifdef LCD_ARB_STATS_EN
    ,
    .stat_pic_words(stat_pic_words),
    .stat_chr_words(stat_chr_words),
    .stat_timeouts (stat_timeouts)
`endif
  );

  // in = {init_done, init_valid, pic_req, pic_valid, chr_req, chr_valid, wr_ready}
  // exp = {init_ready, pic_ready, chr_ready, owner, pic_grant, chr_grant, en_write, data, timeout}
  typedef struct {
    string      nm;
    logic [6:0] in;
    logic [8:0] d;
    logic [2:0] rdy;
    logic [1:0] own;
    logic [1:0] gnt;
    logic       en;
    logic [8:0] dat;
  } vec_t;

  vec_t tv[$];

  task automatic add(input string nm, input logic [6:0] in, input logic [8:0] d,
                     input logic [2:0] rdy, input logic [1:0] own, input logic [1:0] gnt,
                     input logic en, input logic [8:0] dat);
    vec_t v;
    v.nm = nm; v.in = in; v.d = d; v.rdy = rdy; v.own = own; v.gnt = gnt;
    v.en = en; v.dat = dat;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_50MHz);
    #1;
  endtask

  initial begin
    logic [17:0] obs, exp;
    int ok;

    // init burst, pic_req ignored while init owns the port
    add("rst_rel",  7'b0010001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h000);
    add("init_w0",  7'b0110001, 9'h011, 3'b100, 2'd1, 2'b00, 0, 9'h000);
    add("init_w1",  7'b0110001, 9'h036, 3'b100, 2'd1, 2'b00, 1, 9'h011);
    add("init_w2",  7'b0110001, 9'h13A, 3'b100, 2'd1, 2'b00, 1, 9'h036);
    add("init_w3",  7'b0110001, 9'h155, 3'b100, 2'd1, 2'b00, 1, 9'h13A);
    add("init_w4",  7'b0110001, 9'h029, 3'b100, 2'd1, 2'b00, 1, 9'h155);
    add("init_end", 7'b0010001, 9'h000, 3'b100, 2'd1, 2'b00, 1, 9'h029);
    add("init_dn",  7'b1000001, 9'h000, 3'b100, 2'd1, 2'b00, 0, 9'h029);
    // contention: pic first
    add("both_req", 7'b1010101, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h029);
    add("pic_w0",   7'b1011101, 9'h101, 3'b010, 2'd2, 2'b10, 0, 9'h029);
    add("pic_w1",   7'b1011101, 9'h102, 3'b010, 2'd2, 2'b10, 1, 9'h101);
    add("pic_w2",   7'b1011101, 9'h103, 3'b010, 2'd2, 2'b10, 1, 9'h102);
    add("pic_w3",   7'b1011101, 9'h104, 3'b010, 2'd2, 2'b10, 1, 9'h103);
    add("pic_end",  7'b1000101, 9'h000, 3'b000, 2'd2, 2'b10, 1, 9'h104);
    add("gap1",     7'b1000101, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h104);
    add("idle1",    7'b1000101, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h104);
    add("chr_w0",   7'b1000111, 9'h0A1, 3'b001, 2'd3, 2'b01, 0, 9'h104);
    add("chr_w1",   7'b1000111, 9'h0A2, 3'b001, 2'd3, 2'b01, 1, 9'h0A1);
    add("chr_w2",   7'b1000111, 9'h0A3, 3'b001, 2'd3, 2'b01, 1, 9'h0A2);
    add("chr_w3",   7'b1000111, 9'h0A4, 3'b001, 2'd3, 2'b01, 1, 9'h0A3);
    add("chr_end",  7'b1000001, 9'h000, 3'b000, 2'd3, 2'b01, 1, 9'h0A4);
    add("gap2",     7'b1000001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h0A4);
    // backpressure pic burst of 8, wr_ready 1010...
    add("bp_req",   7'b1010001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h0A4);
    add("bp_0",     7'b1011001, 9'h1C0, 3'b010, 2'd2, 2'b10, 0, 9'h0A4);
    add("bp_1s",    7'b1011000, 9'h1C1, 3'b000, 2'd2, 2'b10, 1, 9'h1C0);
    add("bp_1",     7'b1011001, 9'h1C1, 3'b010, 2'd2, 2'b10, 0, 9'h1C0);
    add("bp_2s",    7'b1011000, 9'h1C2, 3'b000, 2'd2, 2'b10, 1, 9'h1C1);
    add("bp_2",     7'b1011001, 9'h1C2, 3'b010, 2'd2, 2'b10, 0, 9'h1C1);
    add("bp_3s",    7'b1011000, 9'h1C3, 3'b000, 2'd2, 2'b10, 1, 9'h1C2);
    add("bp_3",     7'b1011001, 9'h1C3, 3'b010, 2'd2, 2'b10, 0, 9'h1C2);
    add("bp_4s",    7'b1011000, 9'h1C4, 3'b000, 2'd2, 2'b10, 1, 9'h1C3);
    add("bp_4",     7'b1011001, 9'h1C4, 3'b010, 2'd2, 2'b10, 0, 9'h1C3);
    add("bp_5s",    7'b1011000, 9'h1C5, 3'b000, 2'd2, 2'b10, 1, 9'h1C4);
    add("bp_5",     7'b1011001, 9'h1C5, 3'b010, 2'd2, 2'b10, 0, 9'h1C4);
    add("bp_6s",    7'b1011000, 9'h1C6, 3'b000, 2'd2, 2'b10, 1, 9'h1C5);
    add("bp_6",     7'b1011001, 9'h1C6, 3'b010, 2'd2, 2'b10, 0, 9'h1C5);
    add("bp_7s",    7'b1011000, 9'h1C7, 3'b000, 2'd2, 2'b10, 1, 9'h1C6);
    add("bp_7",     7'b1011001, 9'h1C7, 3'b010, 2'd2, 2'b10, 0, 9'h1C6);
    add("bp_end",   7'b1000001, 9'h000, 3'b000, 2'd2, 2'b10, 1, 9'h1C7);
    add("gap3",     7'b1000001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h1C7);
    // contention again: chr wins after a pic burst
    add("both2",    7'b1010101, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h1C7);
    add("chr2_w0",  7'b1010111, 9'h0B1, 3'b001, 2'd3, 2'b01, 0, 9'h1C7);
    add("chr2_end", 7'b1010001, 9'h000, 3'b000, 2'd3, 2'b01, 1, 9'h0B1);
    add("gap4",     7'b1010001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h0B1);
    add("idle4",    7'b1010001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h0B1);
    add("pic2_w0",  7'b1011001, 9'h1D1, 3'b010, 2'd2, 2'b10, 0, 9'h0B1);
    add("pic2_drop",7'b1001001, 9'h1D2, 3'b000, 2'd2, 2'b10, 1, 9'h1D1);
    add("gap5",     7'b1000001, 9'h000, 3'b000, 2'd0, 2'b00, 0, 9'h1D1);

    sys_rst = 1'b1;
    init_done = 0; init_valid = 0; pic_req = 0; pic_valid = 0;
    chr_req = 0; chr_valid = 0; wr_ready = 1;
    init_data = '0; pic_data = '0; chr_data = '0;
    tick();
    tick();
    chk("reset_state", {init_ready, owner, pic_grant, chr_grant, en_write, data, timeout}, 0);
    sys_rst = 1'b0;

    foreach (tv[i]) begin
      {init_done, init_valid, pic_req, pic_valid, chr_req, chr_valid, wr_ready} = tv[i].in;
      init_data = init_valid ? tv[i].d : ~tv[i].d;
      pic_data  = pic_valid  ? tv[i].d : ~tv[i].d;
      chr_data  = chr_valid  ? tv[i].d : ~tv[i].d;
      #1;
      obs = {init_ready, pic_ready, chr_ready, owner, pic_grant, chr_grant, en_write, data, timeout};
      exp = {tv[i].rdy, tv[i].own, tv[i].gnt, tv[i].en, tv[i].dat, 1'b0};
      chk(tv[i].nm, 32'(obs), 32'(exp));
      tick();
    end

    // watchdog: chr granted and idle, pic waiting
    init_done = 1; init_valid = 0; pic_req = 0; pic_valid = 0;
    chr_req = 1; chr_valid = 0; wr_ready = 1;
    tick();
    pic_req = 1;
    chk("wd_grant", {owner, chr_grant}, {2'd3, 1'b1});
    ok = 1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (timeout || !chr_grant) ok = 0;
    end
    chk("wd_no_early", ok, 1);
    tick();
    chk("wd_pulse", {timeout, chr_grant, owner}, {1'b1, 1'b0, 2'd0});
    tick();
    chk("wd_pulse_width", timeout, 0);
    tick();
    chk("wd_pic_after", {pic_grant, chr_grant, owner}, {1'b1, 1'b0, 2'd2});
    chr_req = 0;

    // re-init during pic word 3
    pic_valid = 1; pic_data = 9'h1E1;
    tick();
    pic_data = 9'h1E2;
    tick();
    pic_data = 9'h1E3; init_done = 0;
    #1;
    chk("reinit_last_rdy", pic_ready, 1);
    tick();
    chk("reinit_strobe", {en_write, data}, {1'b1, 9'h1E3});
    chk("reinit_grant", {pic_grant, owner}, {1'b0, 2'd1});
    init_valid = 1; init_data = 9'h0C3; pic_data = 9'h1E4;
    #1;
    chk("reinit_rdy", {init_ready, pic_ready}, {1'b1, 1'b0});
    tick();
    chk("reinit_init_word", {en_write, data}, {1'b1, 9'h0C3});

    // async reset in the middle of a pic burst
    init_valid = 0; init_done = 1; pic_valid = 0;
    tick();
    tick();
    pic_valid = 1; pic_data = 9'h1F0;
    tick();
    chk("pre_rst", {en_write, pic_grant}, {1'b1, 1'b1});
    init_done = 0;
    #2 sys_rst = 1'b1;
    #1;
    chk("rst_async", {en_write, pic_grant, chr_grant, owner, timeout, data}, 0);
    tick();
    sys_rst = 1'b0; pic_valid = 0; pic_req = 0;
    tick();
    chk("rst_to_init", owner, 2'd1);

    // init_done already high at reset release
    sys_rst = 1'b1; init_done = 1; pic_req = 1;
    tick();
    sys_rst = 1'b0;
    tick();
    chk("rel_exit", {owner, pic_grant}, {2'd0, 1'b0});
    tick();
    chk("rel_pic", {owner, pic_grant}, {2'd2, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
Shares the single 9-bit LCD write port between three requesters: the init sequencer, the picture writer and the character-overlay writer. The port word is {dc, byte[7:0]}. The SPI/parallel write engine sits downstream.
- Init owns the port exclusively until init_done.
- After init_done, picture and overlay are arbitrated round-robin, one burst per grant.
- A watchdog revokes a grant held by a stalled requester.

Parameters:
DATA_W, 9, write word width (bit 8 = dc flag)
TIMEOUT, 1024, idle cycles under grant before forced revoke (>=2)
TO_W, 11, watchdog counter width, must satisfy 2^TO_W > TIMEOUT

Ports:
sys_clk_50MHz  in  1  system clock
sys_rst  in  1  asynchronous reset, active-high
init_done  in  1  init sequence complete (level)
init_data  in  9  init word
init_valid  in  1  init word valid
init_ready  out  1  init word accepted this cycle
pic_req  in  1  picture writer requests burst (hold for whole burst)
pic_data  in  9  picture word
pic_valid  in  1  picture word valid
pic_ready  out  1  picture word accepted
pic_grant  out  1  picture writer owns port
chr_req  in  1  overlay requests burst
chr_data  in  9  overlay word
chr_valid  in  1  overlay word valid
chr_ready  out  1  overlay word accepted
chr_grant  out  1  overlay owns port
wr_ready  in  1  downstream can take a word next cycle
data  out  9  word to write engine
en_write  out  1  one-cycle write strobe
owner  out  2  0 none, 1 init, 2 pic, 3 chr
timeout  out  1  one-cycle pulse on forced revoke

Behaviour:
- Reset (async, sys_rst=1): all outputs 0, FSM to S_INIT, rr_last=chr (so pic wins first), watchdog 0.
- Transfer: x_ready = x_grant & wr_ready, combinational. An accept is x_valid & x_ready.
- Registered output: on accept, data <= x_data and en_write <= 1 on the next edge (latency 1). Otherwise en_write <= 0 and data holds. Exactly one strobe per accepted word.
- FSM states:
  - S_INIT: owner=1, init_ready=wr_ready, grants 0. On init_done=1 with no init word accepted this cycle -> S_IDLE.
  - S_IDLE: owner=0, all ready 0.
    - Only pic_req -> S_PIC.
    - Only chr_req -> S_CHR.
    - Both -> the one not equal to rr_last.
    - Grant registers on the cycle after req is seen; no accept possible in S_IDLE.
  - S_PIC / S_CHR: grant=1, owner=2/3. Req deassert -> S_GAP and rr_last <= this source. A word valid in the same cycle as req falling is not accepted.
  - S_GAP: one turnaround cycle, all ready 0 -> S_IDLE.
- Watchdog:
  - In S_PIC/S_CHR it counts cycles without accept and clears on each accept.
  - Stall from wr_ready=0 does not count: increment only when wr_ready=1 and valid=0.
  - At count==TIMEOUT-1: timeout pulse, rr_last <= this source, -> S_GAP.
  - A requester still holding req after revoke is treated as a new request in S_IDLE and subject to round-robin.
- Re-init: init_done falling in any state -> S_INIT next cycle. Any grant drops immediately. An accept in that same cycle still completes (strobe issued).
- init_done high at reset release: S_INIT exits on the first clock.
- Owner and grants are registered and glitch-free; only x_ready is combinational.

Optional Feature:
LCD_ARB_STATS_EN: adds outputs stat_pic_words[15:0], stat_chr_words[15:0] and stat_timeouts[7:0].
- Word counters increment on each accept for their source; stat_timeouts increments on each timeout pulse.
- All three saturate at max and reset to 0.
- Without the macro these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Package lcd_pkg:
  - owner encoding constants OWN_NONE/INIT/PIC/CHR
  - FSM state enum
  - LCD_DW=9
  - dc bit index 8
- Sub-module lcd_arb_watchdog: counter, clear/enable inputs, expire pulse. The FSM and mux stay in the top.

Test Plan:
- Reset then init: 5 init words 0x011,0x036,0x13A,0x155,0x029 with wr_ready=1 -> same 5 words on data, 5 en_write pulses each 1 cycle after accept, owner=1; pic_req ignored until init_done.
- Contention: init_done=1, pic_req and chr_req rise together, each burst of 4 words -> pic bursts first, 1 gap cycle, then chr; repeat with both requests -> chr first this time.
- Backpressure: wr_ready toggles 1010 during pic burst of 8 -> exactly 8 strobes, no duplicates or drops, data order preserved, no timeout.
- Watchdog: TIMEOUT=16, chr granted, chr_valid=0 and wr_ready=1 for 16 cycles -> timeout pulse on cycle 16, chr_grant drops, pending pic granted after gap.
- Re-init mid-burst: init_done drops during pic word 3 of 6 -> word 3 still strobed, pic_grant 0 next cycle, owner=1, init words flow.
- Async reset asserted mid-burst -> en_write, grants and owner 0 immediately; after release FSM is in S_INIT.
